// File: rtl/ascii_pkg.sv
// Shared constants and types for the ASCII decimal-to-binary converter.
// The '-' class is produced only when ASCII_DEC_SIGN_EN is defined.
package ascii_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_DIGIT = 2'd0,
    CLS_TERM  = 2'd1,
    CLS_MINUS = 2'd2,
    CLS_OTHER = 2'd3
  } byte_class_e;

endpackage

// File: rtl/ascii_dec2bin_if.sv
// Byte-stream input and converted-value output bundle for ascii_dec2bin.
interface ascii_dec2bin_if #(
  parameter int OUT_W = 8
);
  logic [7:0]       in;
  logic             w_RX_dv;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             err;
  logic             busy;

  modport master (
    output in, w_RX_dv,
    input  out, out_valid, err, busy
  );

  modport slave (
    input  in, w_RX_dv,
    output out, out_valid, err, busy
  );
endinterface

// File: rtl/ascii_char_class.sv
// Combinational byte classifier: digit / terminator / minus / other, plus digit value.
// With ASCII_DEC_SIGN_EN undefined, '-' falls into the "other" class.
module ascii_char_class
  import ascii_pkg::*;
(
  input  logic [7:0]  ch,
  output byte_class_e cls,
  output logic [3:0]  digit
);

  always_comb begin
    digit = ch[3:0];
    if (ch >= ASCII_0 && ch <= ASCII_9)
      cls = CLS_DIGIT;
    else if (ch == ASCII_CR || ch == ASCII_LF)
      cls = CLS_TERM;
`ifdef ASCII_DEC_SIGN_EN
    else if (ch == ASCII_MINUS)
      cls = CLS_MINUS;
`endif
    else
      cls = CLS_OTHER;
  end

endmodule

// File: rtl/ascii_dec2bin.sv
// ASCII decimal field to binary converter; fields end on CR/LF or after MAX_DIGITS digits.
// Define ASCII_DEC_SIGN_EN for a leading '-' and two's-complement output.
module ascii_dec2bin
  import ascii_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int OUT_W      = 8
) (
  input  logic           clk,
  input  logic           rst,
  ascii_dec2bin_if.slave bus
);

  localparam int ACC_W = OUT_W + 4;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ACCUM = ST_ACCUM;
  localparam logic [1:0] FLUSH = ST_FLUSH;

`ifdef ASCII_DEC_SIGN_EN
  localparam logic [ACC_W-1:0] LIM_POS = {5'b0, {(OUT_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] LIM_NEG = {4'b0, 1'b1, {(OUT_W-1){1'b0}}};
`else
  localparam logic [ACC_W-1:0] LIM_POS = {4'b0, {OUT_W{1'b1}}};
  localparam logic [ACC_W-1:0] LIM_NEG = LIM_POS;
`endif

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic [OUT_W-1:0] out_q;
  logic             out_valid_q;
  logic             err_q;

  byte_class_e      cls;
  logic [3:0]       digit;
  logic [ACC_W-1:0] acc_mul;
  logic [ACC_W-1:0] limit;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf;
  logic             is_last;
  logic [OUT_W-1:0] res_mul;
  logic [OUT_W-1:0] res_acc;

  ascii_char_class u_class (
    .ch    (bus.in),
    .cls   (cls),
    .digit (digit)
  );

  // acc*10 + digit; acc never exceeds 2^OUT_W-1 so ACC_W bits cannot wrap
  assign acc_mul = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit};
  assign limit   = neg ? LIM_NEG : LIM_POS;
  assign ovf     = acc_mul > limit;
  assign cnt_inc = cnt + 1'b1;
  assign is_last = (cnt_inc == CNT_MAX);
  assign res_mul = neg ? (OUT_W'(0) - acc_mul[OUT_W-1:0]) : acc_mul[OUT_W-1:0];
  assign res_acc = neg ? (OUT_W'(0) - acc[OUT_W-1:0]) : acc[OUT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      neg         <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      if (bus.w_RX_dv) begin
        case (state)
          IDLE, ACCUM: begin
            case (cls)
              CLS_DIGIT: begin
                if (ovf) begin
                  // an overflow on the final digit still ends the field, so no flush
                  err_q <= 1'b1;
                  acc   <= '0;
                  cnt   <= '0;
                  neg   <= 1'b0;
                  state <= is_last ? IDLE : FLUSH;
                end else if (is_last) begin
                  out_q       <= res_mul;
                  out_valid_q <= 1'b1;
                  acc         <= '0;
                  cnt         <= '0;
                  neg         <= 1'b0;
                  state       <= IDLE;
                end else begin
                  acc   <= acc_mul;
                  cnt   <= cnt_inc;
                  state <= ACCUM;
                end
              end
              CLS_TERM: begin
                if (state == ACCUM) begin
                  if (cnt == '0) begin
                    err_q <= 1'b1;
                  end else begin
                    out_q       <= res_acc;
                    out_valid_q <= 1'b1;
                  end
                  acc   <= '0;
                  cnt   <= '0;
                  neg   <= 1'b0;
                  state <= IDLE;
                end
              end
              CLS_MINUS: begin
                if (state == IDLE) begin
                  neg   <= 1'b1;
                  state <= ACCUM;
                end else begin
                  err_q <= 1'b1;
                  acc   <= '0;
                  cnt   <= '0;
                  neg   <= 1'b0;
                  state <= FLUSH;
                end
              end
              default: begin
                err_q <= 1'b1;
                acc   <= '0;
                cnt   <= '0;
                neg   <= 1'b0;
                state <= FLUSH;
              end
            endcase
          end
          FLUSH: begin
            if (cls == CLS_TERM)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_ascii_dec2bin.sv
// Self-checking bench for ascii_dec2bin: directed field cases then random byte streams
// against an integer-arithmetic reference. Honours ASCII_DEC_SIGN_EN when defined.
module tb_ascii_dec2bin;

  localparam int MAXD = 3;
  localparam int OW   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ascii_dec2bin_if #(.OUT_W(OW)) bus ();

  ascii_dec2bin #(.MAX_DIGITS(MAXD), .OUT_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference: 0 = between fields, 1 = inside a field, 2 = discarding to terminator
  int      m_mode;
  longint  m_val;
  int      m_nd;
  bit      m_neg;
  longint  m_out;
  bit      m_valid;
  bit      m_err;

  function automatic void model_reset();
    m_mode = 0; m_val = 0; m_nd = 0; m_neg = 0;
    m_out = 0; m_valid = 0; m_err = 0;
  endfunction

  function automatic void end_field(int next_mode);
    m_mode = next_mode; m_val = 0; m_nd = 0; m_neg = 0;
  endfunction

  function automatic void model_step(logic [7:0] b);
    bit     is_dig, is_term, is_minus;
    longint lim;
    m_valid  = 0;
    m_err    = 0;
    is_dig   = (b >= 8'd48) && (b <= 8'd57);
    is_term  = (b == 8'd13) || (b == 8'd10);
`ifdef ASCII_DEC_SIGN_EN
    is_minus = (b == 8'd45);
    lim      = m_neg ? (64'sd1 <<< (OW-1)) : ((64'sd1 <<< (OW-1)) - 1);
`else
    is_minus = 0;
    lim      = (64'sd1 <<< OW) - 1;
`endif
    if (m_mode == 2) begin
      if (is_term) m_mode = 0;
    end else if (is_dig) begin
      m_val = m_val * 10 + longint'(b) - 48;
      m_nd  = m_nd + 1;
      if (m_val > lim) begin
        m_err = 1;
        end_field((m_nd == MAXD) ? 0 : 2);
      end else if (m_nd == MAXD) begin
        m_out   = (m_neg ? -m_val : m_val) & ((64'sd1 <<< OW) - 1);
        m_valid = 1;
        end_field(0);
      end else begin
        m_mode = 1;
      end
    end else if (is_term) begin
      if (m_mode == 1) begin
        if (m_nd == 0) m_err = 1;
        else begin
          m_out   = (m_neg ? -m_val : m_val) & ((64'sd1 <<< OW) - 1);
          m_valid = 1;
        end
        end_field(0);
      end
    end else if (is_minus && m_mode == 0) begin
      m_neg  = 1;
      m_mode = 1;
    end else begin
      m_err = 1;
      end_field(2);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_out"},   32'(bus.out),       32'(m_out));
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, "_err"},   32'(bus.err),       32'(m_err));
    chk({tag, "_busy"},  32'(bus.busy),      32'(m_mode != 0));
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    bus.in      = b;
    bus.w_RX_dv = 1'b1;
    @(posedge clk); #1;
    bus.w_RX_dv = 1'b0;
    bus.in      = 8'h00;
    model_step(b);
    chk_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      bus.in = 8'($urandom);
      @(posedge clk); #1;
      m_valid = 0;
      m_err   = 0;
      chk_all(tag);
    end
  endtask

  logic [7:0] pick;
  int         r;

  initial begin
    bus.in      = 8'h00;
    bus.w_RX_dv = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 1'b0;
    idle(1, "post_reset");

`ifndef ASCII_DEC_SIGN_EN
    send("2", "f255_a"); send("5", "f255_b"); send("5", "f255_c");
    chk("f255_const_out", 32'(bus.out), 32'd255);
    chk("f255_const_valid", 32'(bus.out_valid), 32'd1);
`endif
    idle(1, "gap0");
    send("4", "f42_a"); send("2", "f42_b"); send(8'h0D, "f42_cr");
    chk("f42_const_out", 32'(bus.out), 32'd42);
    send(8'h0D, "lone_cr");
    chk("lone_cr_no_valid", 32'(bus.out_valid), 32'd0);

    send("2", "f256_a"); send("5", "f256_b"); send("6", "f256_c");
    chk("f256_const_err", 32'(bus.err), 32'd1);
    chk("f256_out_held", 32'(bus.out), 32'd42);
    send("7", "f7_a"); send(8'h0A, "f7_lf");
    chk("f7_const_out", 32'(bus.out), 32'd7);

    send("1", "f1a3_a"); send("A", "f1a3_b");
    chk("f1a3_err", 32'(bus.err), 32'd1);
    send("3", "f1a3_c");
    send(8'h0D, "f1a3_cr");
    chk("f1a3_busy_after_cr", 32'(bus.busy), 32'd0);
    send("-", "minus_first");
    send("5", "minus_digit"); send(8'h0D, "minus_cr");

`ifdef ASCII_DEC_SIGN_EN
    send("-", "n128_m"); send("1", "n128_a"); send("2", "n128_b"); send("8", "n128_c");
    chk("n128_const_out", 32'(bus.out), 32'h80);
    send(8'h0D, "n128_cr");
    send("1", "p128_a"); send("2", "p128_b"); send("8", "p128_c");
    chk("p128_const_err", 32'(bus.err), 32'd1);
    send(8'h0D, "p128_cr");
    send("-", "lone_m"); send(8'h0D, "lone_m_cr");
    chk("lone_minus_err", 32'(bus.err), 32'd1);
`endif

    // asynchronous reset mid-field
    send("9", "rst_a"); send("9", "rst_b");
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk_all("rst_immediate");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2, "rst_release");
    send("3", "rst_f3"); send(8'h0D, "rst_f3_cr");
    chk("rst_f3_const_out", 32'(bus.out), 32'd3);

    // back-to-back and randomly spaced bytes
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      pick = 8'(8'd48 + $urandom_range(0, 9));
      else if (r < 75) pick = 8'h0D;
      else if (r < 82) pick = 8'h0A;
      else if (r < 90) pick = 8'h2D;
      else             pick = 8'($urandom);
      send(pick, "rand");
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2), "rand_gap");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_dec2bin.md
ASCII_DEC2BIN -- requirements
Module: ascii_dec2bin

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 3, the maximum number of decimal digits per field (legal 1..10).
REQ-002 SHALL have parameter OUT_W, default 8, the binary result width (legal 4..32).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in  input  8  the ASCII byte from the UART receiver.
REQ-006 SHALL have port w_RX_dv  input  1  a one-cycle strobe marking `in` valid.
REQ-007 SHALL have port out  output  OUT_W  the converted value, held until the next completed field.
REQ-008 SHALL have port out_valid  output  1  a one-cycle pulse when `out` updates.
REQ-009 SHALL have port err  output  1  a one-cycle pulse on a malformed or overflowing field.
REQ-010 SHALL have port busy  output  1  high while a field is partially received.

Function
REQ-011 SHALL sample `in` only in cycles where w_RX_dv=1, and SHALL ignore all other cycles.
REQ-012 SHALL classify each byte as one of: digit (0x30-0x39), terminator (0x0D or 0x0A), or other.
REQ-013 SHALL implement states IDLE, ACCUM and FLUSH.
REQ-014 SHALL make busy=1 exactly in ACCUM and FLUSH.
REQ-015 SHALL, on a digit, update the accumulator to acc*10+digit, using an internal width of OUT_W+4 bits.
REQ-016 SHALL, on the first digit in IDLE, move to ACCUM.
REQ-017 SHALL complete the field on a terminator in ACCUM, or automatically on the MAX_DIGITS-th digit.
REQ-018 SHALL, on completion, register `out` and pulse out_valid in the cycle after the completing strobe (latency 1), then return to IDLE.
REQ-019 SHALL ignore a terminator received in IDLE (empty field): no out_valid and no err.
REQ-020 SHALL, on an "other" byte in IDLE or ACCUM, pulse err on the next cycle, discard the accumulator and enter FLUSH.
REQ-021 SHALL, in FLUSH, discard all bytes until a terminator, then return to IDLE with no further err.
REQ-022 SHALL treat an accumulator exceeding 2^OUT_W-1 as overflow, handled identically to REQ-020.
REQ-023 SHALL accept back-to-back strobes: a byte arriving in the cycle after completion SHALL be processed normally.
REQ-024 SHALL accept leading zeros, which count toward MAX_DIGITS.

Reset
REQ-025 SHALL, on rst assertion, immediately force state=IDLE, accumulator=0, digit count=0, out=0, out_valid=0, err=0, busy=0.
REQ-026 SHALL discard any partial field when rst is asserted mid-field, with no out_valid or err after release.

Configuration
REQ-027 SHALL, when ASCII_DEC_SIGN_EN is defined, accept '-' (0x2D) only as the first byte of a field.
REQ-028 SHALL, with ASCII_DEC_SIGN_EN defined, make `out` two's complement.
REQ-029 SHALL, with ASCII_DEC_SIGN_EN defined, use an overflow limit of 2^(OUT_W-1)-1 for positive fields and 2^(OUT_W-1) for negative fields.
REQ-030 SHALL, with ASCII_DEC_SIGN_EN defined, treat a lone '-' followed by a terminator as an error.
REQ-031 SHALL, without ASCII_DEC_SIGN_EN, treat '-' as an "other" byte and interpret `out` as unsigned.

Structure
REQ-032 SHALL take the shared package ascii_pkg, which holds the character constants (ASCII_0, ASCII_9, ASCII_CR, ASCII_LF, ASCII_MINUS), the state enum and the byte-class typedef.
REQ-033 SHALL contain the sub-module ascii_char_class (combinational: byte -> class, 4-bit digit value).

Verification
REQ-034 SHALL verify: OUT_W=8, MAX_DIGITS=3; bytes "2","5","5" -> out=255, out_valid one cycle after the third strobe, no terminator needed.
REQ-035 SHALL verify: bytes "4","2",CR -> out=42, out_valid one cycle after CR; a following CR alone -> no pulse.
REQ-036 SHALL verify: bytes "2","5","6" -> err pulse, out unchanged; next field "7",LF -> out=7.
REQ-037 SHALL verify: bytes "1","A","3",CR -> err after "A", FLUSH until CR, busy=0 after CR; a single err only.
REQ-038 SHALL verify: with ASCII_DEC_SIGN_EN, OUT_W=8, bytes "-","1","2","8",CR -> out=8'h80; "1","2","8",CR -> err.
REQ-039 SHALL verify: rst asserted after "9","9" -> outputs 0 immediately; then "3",CR -> out=3.
